// File: rtl/riscv_pkg.sv
// riscv_pkg: RV64I opcode constants plus the opclass and immediate-format enums
// shared by the decode/issue stage.
package riscv_pkg;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   typedef enum logic [3:0] {
      CL_LUI       = 4'd0,
      CL_AUIPC     = 4'd1,
      CL_JAL       = 4'd2,
      CL_JALR      = 4'd3,
      CL_BRANCH    = 4'd4,
      CL_LOAD      = 4'd5,
      CL_STORE     = 4'd6,
      CL_OP_IMM    = 4'd7,
      CL_OP        = 4'd8,
      CL_OP_IMM_32 = 4'd9,
      CL_OP_32     = 4'd10,
      CL_SYSTEM    = 4'd11,
      CL_ILLEGAL   = 4'd15
   } opclass_e;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5
   } imm_fmt_e;
endpackage

// File: rtl/imm_gen.sv
// imm_gen: RV64I immediate extraction for the I/S/B/U/J formats, sign-extended
// from instruction bit 31 to XLEN.
module imm_gen
   import riscv_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:7]     instr_i,
   input  imm_fmt_e        fmt_i,
   output logic [XLEN-1:0] imm_o
);
   logic [31:0] imm32;

   // the opcode bits never contribute, so only [31:7] is taken
   assign imm32 = fmt_i == FMT_I ? {{20{instr_i[31]}}, instr_i[31:20]} :
                  fmt_i == FMT_S ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
                  fmt_i == FMT_B ? {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
                  fmt_i == FMT_U ? {instr_i[31:12], 12'b0} :
                  fmt_i == FMT_J ? {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
                  32'b0;

   assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/decode_issue.sv
// decode_issue: RV64I decode with register-file read, 32-entry busy scoreboard
// and a one-entry valid/ready output register toward execute.
module decode_issue
   import riscv_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int ADDR_SIZE = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [XLEN-1:0]      in_pc,
   output logic                 rf_read_enable1,
   output logic                 rf_read_enable2,
   output logic [ADDR_SIZE-1:0] rf_read_addr1,
   output logic [ADDR_SIZE-1:0] rf_read_addr2,
   input  logic [XLEN-1:0]      rf_read_data1,
   input  logic [XLEN-1:0]      rf_read_data2,
   input  logic                 wb_valid,
   input  logic [ADDR_SIZE-1:0] wb_addr,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_pc,
   output logic [XLEN-1:0]      out_rs1_data,
   output logic [XLEN-1:0]      out_rs2_data,
   output logic [XLEN-1:0]      out_imm,
   output logic [ADDR_SIZE-1:0] out_rd,
   output logic                 out_we,
   output logic [3:0]           out_opclass,
   output logic [9:0]           out_funct,
   output logic                 out_illegal
);
   logic [4:0]            rs1, rs2, rd, wb_idx;
   opclass_e              cls;
   imm_fmt_e              fmt;
   logic                  use1, use2, wr, we, hazard, accept;
   logic [XLEN-1:0]       imm;
   logic [31:0]           busy_q, busy_d, wb_clr, live;
   logic                  out_valid_q, out_valid_d;
   logic [XLEN-1:0]       out_pc_q, out_rs1_data_q, out_rs2_data_q, out_imm_q;
   logic [ADDR_SIZE-1:0]  out_rd_q;
   logic                  out_we_q, out_illegal_q;
   logic [3:0]            out_opclass_q;
   logic [9:0]            out_funct_q;

   assign rs1 = in_instr[19:15];
   assign rs2 = in_instr[24:20];
   assign rd  = in_instr[11:7];

   always_comb begin
      cls  = CL_ILLEGAL;
      fmt  = FMT_NONE;
      use1 = 1'b0;
      use2 = 1'b0;
      wr   = 1'b0;
      case (in_instr[6:0])
         OPC_LUI:       begin cls = CL_LUI;       fmt = FMT_U; wr = 1'b1; end
         OPC_AUIPC:     begin cls = CL_AUIPC;     fmt = FMT_U; wr = 1'b1; end
         OPC_JAL:       begin cls = CL_JAL;       fmt = FMT_J; wr = 1'b1; end
         OPC_JALR:      begin cls = CL_JALR;      fmt = FMT_I; use1 = 1'b1; wr = 1'b1; end
         OPC_BRANCH:    begin cls = CL_BRANCH;    fmt = FMT_B; use1 = 1'b1; use2 = 1'b1; end
         OPC_LOAD:      begin cls = CL_LOAD;      fmt = FMT_I; use1 = 1'b1; wr = 1'b1; end
         OPC_STORE:     begin cls = CL_STORE;     fmt = FMT_S; use1 = 1'b1; use2 = 1'b1; end
         OPC_OP_IMM:    begin cls = CL_OP_IMM;    fmt = FMT_I; use1 = 1'b1; wr = 1'b1; end
         OPC_OP:        begin cls = CL_OP;        use1 = 1'b1; use2 = 1'b1; wr = 1'b1; end
         OPC_OP_IMM_32: begin cls = CL_OP_IMM_32; fmt = FMT_I; use1 = 1'b1; wr = 1'b1; end
         OPC_OP_32:     begin cls = CL_OP_32;     use1 = 1'b1; use2 = 1'b1; wr = 1'b1; end
         OPC_SYSTEM:    begin cls = CL_SYSTEM;    fmt = FMT_I; use1 = 1'b1; wr = 1'b1; end
         default: ;
      endcase
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr_i (in_instr[31:7]),
      .fmt_i   (fmt),
      .imm_o   (imm)
   );

   assign we              = wr && rd != 5'd0;
   assign rf_read_enable1 = in_valid && use1;
   assign rf_read_enable2 = in_valid && use2;
   assign rf_read_addr1   = ADDR_SIZE'(rs1);
   assign rf_read_addr2   = ADDR_SIZE'(rs2);

   // a writeback landing this cycle already frees its register for the incoming op
   assign wb_idx = 5'(wb_addr);
   assign wb_clr = wb_valid ? 32'd1 << wb_idx : 32'd0;
   assign live   = busy_q & ~wb_clr;
   assign hazard = in_valid && ((use1 && live[rs1]) || (use2 && live[rs2]) || (we && live[rd]));
   assign in_ready = rst && (!out_valid_q || out_ready) && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      busy_d = live;
      if (accept && we) busy_d[rd] = 1'b1;
      if (flush) busy_d = '0;
      busy_d[0] = 1'b0;
   end

   assign out_valid_d = flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : out_valid_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q         <= '0;
         out_valid_q    <= 1'b0;
         out_pc_q       <= '0;
         out_rs1_data_q <= '0;
         out_rs2_data_q <= '0;
         out_imm_q      <= '0;
         out_rd_q       <= '0;
         out_we_q       <= 1'b0;
         out_opclass_q  <= '0;
         out_funct_q    <= '0;
         out_illegal_q  <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         if (accept) begin
            out_pc_q       <= in_pc;
            out_rs1_data_q <= rf_read_data1;
            out_rs2_data_q <= rf_read_data2;
            out_imm_q      <= imm;
            out_rd_q       <= ADDR_SIZE'(rd);
            out_we_q       <= we;
            out_opclass_q  <= cls;
            out_funct_q    <= {in_instr[31:25], in_instr[14:12]};
            out_illegal_q  <= cls == CL_ILLEGAL;
         end
      end
   end

   assign out_valid    = out_valid_q;
   assign out_pc       = out_pc_q;
   assign out_rs1_data = out_rs1_data_q;
   assign out_rs2_data = out_rs2_data_q;
   assign out_imm      = out_imm_q;
   assign out_rd       = out_rd_q;
   assign out_we       = out_we_q;
   assign out_opclass  = out_opclass_q;
   assign out_funct    = out_funct_q;
   assign out_illegal  = out_illegal_q;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed bench for decode_issue; expected issue packets are
// queued when an instruction is driven and checked when it reaches the output.
module tb_decode_issue;
   import riscv_pkg::*;

   logic        clk, rst, in_valid, in_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc, rf_read_data1, rf_read_data2;
   logic        rf_read_enable1, rf_read_enable2;
   logic [4:0]  rf_read_addr1, rf_read_addr2, wb_addr, out_rd;
   logic        wb_valid, flush, out_valid, out_ready, out_we, out_illegal;
   logic [63:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
   logic [3:0]  out_opclass;
   logic [9:0]  out_funct;

   typedef struct {
      logic [63:0] pc, d1, d2, imm;
      logic [4:0]  rd;
      logic        we;
      logic [3:0]  cls;
      logic [9:0]  fn;
      logic        ill;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   decode_issue #(.XLEN(64), .ADDR_SIZE(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .rf_read_enable1(rf_read_enable1), .rf_read_enable2(rf_read_enable2),
      .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
      .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
      .out_rd(out_rd), .out_we(out_we), .out_opclass(out_opclass),
      .out_funct(out_funct), .out_illegal(out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] d1,
                        input logic [63:0] d2, input logic [63:0] imm, input logic [4:0] rd,
                        input logic we, input logic [3:0] cls, input logic [9:0] fn, input logic ill);
      exp_t e;
      in_valid = 1'b1;
      in_instr = ins;
      in_pc = pc;
      rf_read_data1 = d1;
      rf_read_data2 = d2;
      e.pc = pc; e.d1 = d1; e.d2 = d2; e.imm = imm; e.rd = rd;
      e.we = we; e.cls = cls; e.fn = fn; e.ill = ill;
      q.push_back(e);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      n_cmp++;
      assert (q.size() != 0) else begin
         n_err++;
         $error("FAIL %s.queue observed=empty expected=entry", tag);
      end
      if (q.size() != 0) begin
         e = q.pop_front();
         chk({tag, ".valid"}, 64'(out_valid), 64'd1);
         chk({tag, ".pc"}, out_pc, e.pc);
         chk({tag, ".rs1"}, out_rs1_data, e.d1);
         chk({tag, ".rs2"}, out_rs2_data, e.d2);
         chk({tag, ".imm"}, out_imm, e.imm);
         chk({tag, ".rd"}, 64'(out_rd), 64'(e.rd));
         chk({tag, ".we"}, 64'(out_we), 64'(e.we));
         chk({tag, ".cls"}, 64'(out_opclass), 64'(e.cls));
         chk({tag, ".funct"}, 64'(out_funct), 64'(e.fn));
         chk({tag, ".ill"}, 64'(out_illegal), 64'(e.ill));
      end
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      rf_read_data1 = '0; rf_read_data2 = '0; wb_valid = 1'b0; wb_addr = '0;
      flush = 1'b0; out_ready = 1'b1;
      #2;
      chk("rst.valid", 64'(out_valid), 64'd0);
      chk("rst.ready", 64'(in_ready), 64'd0);
      chk("rst.imm", out_imm, 64'd0);
      chk("rst.pc", out_pc, 64'd0);
      chk("rst.ill", 64'(out_illegal), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rel.ready", 64'(in_ready), 64'd1);
      chk("idle.rden1", 64'(rf_read_enable1), 64'd0);
      tick();

      // ADDI x5,x0,-1 then dependent ADD x6,x5,x5
      drive(32'hFFF00293, 64'h1000, 64'h11, 64'h22, '1, 5'd5, 1'b1, CL_OP_IMM, 10'h3F8, 1'b0);
      #1;
      chk("addi.rden1", 64'(rf_read_enable1), 64'd1);
      chk("addi.rden2", 64'(rf_read_enable2), 64'd0);
      chk("addi.ready", 64'(in_ready), 64'd1);
      tick();
      check_out("addi");
      chk("addi.busy5", 64'(dut.busy_q[5]), 64'd1);
      in_instr = 32'h00528333; in_pc = 64'h1004; rf_read_data1 = 64'h5;
      #1;
      chk("add.rden2", 64'(rf_read_enable2), 64'd1);
      chk("add.raddr1", 64'(rf_read_addr1), 64'd5);
      for (int i = 0; i < 3; i++) begin
         chk("add.stall", 64'(in_ready), 64'd0);
         tick();
      end
      chk("add.drained", 64'(out_valid), 64'd0);
      wb_valid = 1'b1; wb_addr = 5'd5;
      drive(32'h00528333, 64'h1004, 64'hABCD, 64'hABCD, 64'd0, 5'd6, 1'b1, CL_OP, 10'h000, 1'b0);
      #1;
      chk("add.wbready", 64'(in_ready), 64'd1);
      tick();
      wb_valid = 1'b0;
      check_out("add");
      chk("add.busy5", 64'(dut.busy_q[5]), 64'd0);

      // downstream stall for 3 cycles with LUI x7 waiting
      out_ready = 1'b0;
      in_instr = 32'h800003B7; in_pc = 64'h1008; rf_read_data1 = 64'h1; rf_read_data2 = 64'h2;
      #1;
      chk("lui.rden1", 64'(rf_read_enable1), 64'd0);
      for (int i = 0; i < 3; i++) begin
         chk("hold.ready", 64'(in_ready), 64'd0);
         chk("hold.rd", 64'(out_rd), 64'd6);
         chk("hold.pc", out_pc, 64'h1004);
         chk("hold.rs1", out_rs1_data, 64'hABCD);
         tick();
      end
      chk("hold.valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      drive(32'h800003B7, 64'h1008, 64'h1, 64'h2, 64'hFFFF_FFFF_8000_0000, 5'd7, 1'b1, CL_LUI, 10'h200, 1'b0);
      #1;
      chk("lui.ready", 64'(in_ready), 64'd1);
      tick();
      check_out("lui");

      // issue to busy x7 while x7 writes back: set wins
      wb_valid = 1'b1; wb_addr = 5'd7;
      drive(32'h00500393, 64'h100C, 64'h3, 64'h4, 64'd5, 5'd7, 1'b1, CL_OP_IMM, 10'h000, 1'b0);
      #1;
      chk("x7.ready", 64'(in_ready), 64'd1);
      tick();
      wb_valid = 1'b0;
      check_out("x7");
      chk("x7.busy", 64'(dut.busy_q[7]), 64'd1);

      drive(32'h00100013, 64'h1010, 64'd0, 64'd0, 64'd1, 5'd0, 1'b0, CL_OP_IMM, 10'h000, 1'b0);
      tick();
      check_out("x0");
      chk("x0.busy", 64'(dut.busy_q[0]), 64'd0);

      drive(32'h0000037F, 64'h1014, 64'd0, 64'd0, 64'd0, 5'd6, 1'b0, CL_ILLEGAL, 10'h000, 1'b1);
      tick();
      check_out("ill");
      chk("ill.busy", 64'(dut.busy_q), 64'h0000_00C0);

      // back-to-back SW, BEQ, JAL
      drive(32'hFE20AE23, 64'h1018, 64'h100, 64'h200, 64'hFFFF_FFFF_FFFF_FFFC, 5'd28, 1'b0, CL_STORE, 10'h3FA, 1'b0);
      #1;
      chk("sw.rden2", 64'(rf_read_enable2), 64'd1);
      chk("sw.raddr2", 64'(rf_read_addr2), 64'd2);
      tick();
      check_out("sw");
      drive(32'h00000863, 64'h101C, 64'd0, 64'd0, 64'd16, 5'd16, 1'b0, CL_BRANCH, 10'h000, 1'b0);
      tick();
      check_out("beq");
      drive(32'hFFDFF0EF, 64'h1020, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 1'b1, CL_JAL, 10'h3FF, 1'b0);
      tick();
      check_out("jal");

      // flush with a held entry and busy x3, x9
      drive(32'h00100193, 64'h1024, 64'd0, 64'd0, 64'd1, 5'd3, 1'b1, CL_OP_IMM, 10'h000, 1'b0);
      tick();
      check_out("x3");
      drive(32'h00200493, 64'h1028, 64'd0, 64'd0, 64'd2, 5'd9, 1'b1, CL_OP_IMM, 10'h000, 1'b0);
      tick();
      check_out("x9");
      chk("pre.busy", 64'(dut.busy_q & 32'h208), 64'h208);
      out_ready = 1'b0; flush = 1'b1; in_instr = 32'h00100513;
      #1;
      chk("flush.ready", 64'(in_ready), 64'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush.valid", 64'(out_valid), 64'd0);
      chk("flush.busy", 64'(dut.busy_q), 64'd0);

      // asynchronous reset while an entry is stalled
      drive(32'hFFF00293, 64'h1030, 64'h7, 64'h8, '1, 5'd5, 1'b1, CL_OP_IMM, 10'h3F8, 1'b0);
      tick();
      check_out("pre_rst");
      in_valid = 1'b0;
      tick();
      chk("stall.valid", 64'(out_valid), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst.valid", 64'(out_valid), 64'd0);
      chk("arst.ready", 64'(in_ready), 64'd0);
      chk("arst.imm", out_imm, 64'd0);
      chk("arst.pc", out_pc, 64'd0);
      chk("arst.rd", 64'(out_rd), 64'd0);
      chk("arst.we", 64'(out_we), 64'd0);
      chk("arst.rs1", out_rs1_data, 64'd0);
      chk("arst.busy", 64'(dut.busy_q), 64'd0);
      rst = 1'b1; out_ready = 1'b1;
      tick();
      chk("post.ready", 64'(in_ready), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 Parameter XLEN, default 64: datapath width.
REQ-002 Parameter ADDR_SIZE, default 5: register address width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 in_valid / in_ready  in / out  1 each  fetch handshake.
REQ-007 in_instr  in  32  RV64I instruction word; in_pc  in  XLEN  its PC.
REQ-008 rf_read_enable1/2  out  1 each; rf_read_addr1/2  out  ADDR_SIZE each  register-file read port drive.
REQ-009 rf_read_data1/2  in  XLEN each  register-file read data, same cycle.
REQ-010 wb_valid  in  1; wb_addr  in  ADDR_SIZE  writeback completion, clears scoreboard.
REQ-011 flush  in  1  kill held entry and clear scoreboard.
REQ-012 out_valid / out_ready  out / in  1 each  execute handshake.
REQ-013 out_pc, out_rs1_data, out_rs2_data, out_imm  out  XLEN each; out_rd  out  ADDR_SIZE; out_we  out  1; out_opclass  out  4; out_funct  out  10 ({funct7,funct3}); out_illegal  out  1.

Function
REQ-014 Decode SHALL be combinational on in_instr: rs1=[19:15], rs2=[24:20], rd=[11:7]; rf_read_enable1/2 asserted only when in_valid is high and the format uses rs1/rs2.
REQ-015 Immediates (I,S,B,U,J) SHALL be sign-extended from bit 31 to XLEN; U-type places [31:12] at [31:12], zero low bits, then sign-extends.
REQ-016 opclass SHALL be LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, OP_IMM_32, OP_32, SYSTEM or ILLEGAL; an unknown opcode yields ILLEGAL, out_illegal=1, out_we=0.
REQ-017 out_we=1 only for classes that write rd and rd!=0.
REQ-018 Scoreboard: 32 busy bits; busy[0] is constantly 0.
REQ-019 Hazard SHALL be asserted when a used source, or rd with out_we=1 (WAW), is busy and not cleared by wb_valid/wb_addr in the same cycle.
REQ-020 in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-021 On in_valid && in_ready, the output register SHALL load all decoded fields plus rf_read_data1/2 at the next edge; out_valid=1. Latency is one cycle.
REQ-022 On accept with out_we=1, busy[rd] SHALL be set; wb_valid clears busy[wb_addr]; on a simultaneous set and clear of the same index, set wins.
REQ-023 out_valid && !out_ready SHALL hold all out_* stable.
REQ-024 out_valid drops after out_ready when no new accept occurs.
REQ-025 flush SHALL clear out_valid and all busy bits at the next edge and accept nothing that cycle; downstream issues no wb_valid for flushed ops.
REQ-026 Back-to-back accepts with out_ready held high SHALL sustain one instruction per cycle.

Reset
REQ-027 While rst=0: out_valid=0, all busy bits=0, out_* data fields=0, out_illegal=0; in_ready=0 during reset and 1 in the first cycle after release.
REQ-028 Reset asserted mid-transfer SHALL discard the held entry with no partial state.

Structure
REQ-029 Opcode constants, opclass enum and imm-format enum SHALL live in shared package riscv_pkg.
REQ-030 Immediate generation SHALL be sub-module imm_gen (instr, format -> XLEN immediate); scoreboard and output register stay in decode_issue.

Verification
REQ-031 ADDI x5,x0,-1 (0xFFF00293), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFF_FFFF_FFFF_FFFF, out_rd=5, out_we=1; busy[5]=1.
REQ-032 ADD x6,x5,x5 directly after -> in_ready=0 until wb_valid, wb_addr=5; accepted in that cycle with out_rs1_data equal to the freshly written rf_read_data1.
REQ-033 out_ready=0 for 3 cycles with an entry held -> out_* stable, in_ready=0; release -> next instruction issues the following cycle.
REQ-034 Opcode 0x7F -> out_illegal=1, out_opclass=ILLEGAL, out_we=0, no busy bit set.
REQ-035 Write to x0 (ADDI x0,x0,1) -> out_we=0, busy[0]=0; same-cycle issue setting busy[7] and wb clearing x7 -> busy[7]=1.
REQ-036 flush with held entry and busy[3,9] set -> out_valid=0, all busy 0 next cycle; async rst low mid-stall -> all outputs 0 immediately.
